// File: rtl/fpu_pkg.sv
// Shared FPU types: requester state, in-flight tag, and the fadd pipeline depth.
package fpu_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE     = 2'd0,
        ARB_INFLIGHT = 2'd1,
        ARB_HOLD     = 2'd2
    } arb_state_t;

    // Tag id is sized for the largest supported requester count (8).
    localparam int ARB_ID_W = 3;

    typedef struct packed {
        logic                vld;
        logic [ARB_ID_W-1:0] id;
    } fadd_tag_t;

    localparam int FADD_LATENCY = 3;

endpackage

// File: rtl/fadd.sv
// Three-stage pipelined single-precision adder: align, add, normalise/round (RNE).
// Denormal inputs and underflowing results are flushed to zero; overflow gives infinity.
module fadd (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        input_valid,
    input  logic [31:0] input_a,
    input  logic [31:0] input_b,
    output logic        out_valid,
    output logic [31:0] result
);
    logic [30:0] mag_a_s, mag_b_s, big_s, small_s;
    logic        swap_s;
    logic        v1_r, s1_sign_r, s1_sub_r;
    logic [7:0]  s1_exp_r, s1_diff_r;
    logic [23:0] s1_mbig_r, s1_msmall_r;
    logic [26:0] ext_s, shifted_s, mask_s, aligned_s;
    logic        far_s, sticky_s;
    logic [27:0] sum_s;
    logic        v2_r, s2_sign_r;
    logic [7:0]  s2_exp_r;
    logic [27:0] s2_sum_r;
    logic [4:0]  lz_s;
    logic [26:0] norm_s;
    logic signed [9:0] exp_ext_s, e_norm_s, e_fin_s;
    logic        round_up_s;
    logic [24:0] mant_s;
    logic [22:0] frac_s;
    logic [31:0] pack_s;
    logic        v3_r;
    logic [31:0] result_r;

    // Stage 1 decode: flush denormals and order the operands by magnitude
    always_comb begin
        mag_a_s = (input_a[30:23] == 8'd0) ? 31'd0 : input_a[30:0];
        mag_b_s = (input_b[30:23] == 8'd0) ? 31'd0 : input_b[30:0];
        swap_s  = (mag_b_s > mag_a_s);
        big_s   = swap_s ? mag_b_s : mag_a_s;
        small_s = swap_s ? mag_a_s : mag_b_s;
    end

    // Stage 1 register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1_r        <= 1'b0;
            s1_sign_r   <= 1'b0;
            s1_sub_r    <= 1'b0;
            s1_exp_r    <= 8'd0;
            s1_diff_r   <= 8'd0;
            s1_mbig_r   <= 24'd0;
            s1_msmall_r <= 24'd0;
        end else begin
            v1_r        <= input_valid;
            s1_sign_r   <= swap_s ? input_b[31] : input_a[31];
            s1_sub_r    <= input_a[31] ^ input_b[31];
            s1_exp_r    <= big_s[30:23];
            s1_diff_r   <= big_s[30:23] - small_s[30:23];
            s1_mbig_r   <= {|big_s[30:23], big_s[22:0]};
            s1_msmall_r <= {|small_s[30:23], small_s[22:0]};
        end
    end

    // Stage 2 datapath: align the smaller mantissa with guard/round/sticky, then add or subtract
    always_comb begin
        ext_s     = {s1_msmall_r, 3'b000};
        far_s     = (s1_diff_r >= 8'd27);
        shifted_s = ext_s >> s1_diff_r[4:0];
        mask_s    = ~({27{1'b1}} << s1_diff_r[4:0]);
        sticky_s  = far_s ? (|s1_msmall_r) : (|(ext_s & mask_s));
        aligned_s = far_s ? {26'd0, sticky_s} : {shifted_s[26:1], shifted_s[0] | sticky_s};
        sum_s     = s1_sub_r ? ({1'b0, s1_mbig_r, 3'b000} - {1'b0, aligned_s})
                             : ({1'b0, s1_mbig_r, 3'b000} + {1'b0, aligned_s});
    end

    // Stage 2 register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v2_r      <= 1'b0;
            s2_sign_r <= 1'b0;
            s2_exp_r  <= 8'd0;
            s2_sum_r  <= 28'd0;
        end else begin
            v2_r      <= v1_r;
            s2_sign_r <= s1_sign_r;
            s2_exp_r  <= s1_exp_r;
            s2_sum_r  <= sum_s;
        end
    end

    // Stage 3 datapath: normalise, round to nearest even and pack
    always_comb begin
        lz_s = 5'd27;
        for (int i = 0; i < 27; i++) begin
            if (s2_sum_r[i]) lz_s = 5'(26 - i);
            else             lz_s = lz_s;
        end
        exp_ext_s = $signed({2'b00, s2_exp_r});
        if (s2_sum_r[27]) begin
            norm_s   = {s2_sum_r[27:2], s2_sum_r[1] | s2_sum_r[0]};
            e_norm_s = exp_ext_s + 10'sd1;
        end else begin
            norm_s   = s2_sum_r[26:0] << lz_s;
            e_norm_s = exp_ext_s - $signed({5'd0, lz_s});
        end
        round_up_s = norm_s[2] & (norm_s[1] | norm_s[0] | norm_s[3]);
        mant_s     = {1'b0, norm_s[26:3]} + {24'd0, round_up_s};
        frac_s     = mant_s[24] ? mant_s[23:1] : mant_s[22:0];
        e_fin_s    = e_norm_s + $signed({9'd0, mant_s[24]});
        if (s2_sum_r == 28'd0)         pack_s = 32'd0;
        else if (e_fin_s <= 10'sd0)    pack_s = {s2_sign_r, 31'd0};
        else if (e_fin_s >= 10'sd255)  pack_s = {s2_sign_r, 8'hFF, 23'd0};
        else                           pack_s = {s2_sign_r, e_fin_s[7:0], frac_s};
    end

    // Output register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v3_r     <= 1'b0;
            result_r <= 32'd0;
        end else begin
            v3_r     <= v2_r;
            result_r <= pack_s;
        end
    end

    assign out_valid = v3_r;
    assign result    = result_r;

endmodule

// File: rtl/fadd_arbiter_chk.sv
// Simulation checker: the tag pipe's last stage must be valid exactly when the fadd reports out_valid.
module fadd_arbiter_chk (
    input logic clk,
    input logic rst_n,
    input logic tag_vld,
    input logic out_valid
);
    // Compare mid-cycle, away from the register updates
    always @(negedge clk) begin
        if (rst_n) begin
            assert (tag_vld == out_valid)
                else $fatal(1, "FAIL tag_align tag_vld=%0b out_valid=%0b", tag_vld, out_valid);
        end
    end
endmodule

// File: rtl/fadd_arbiter_rr.sv
// Combinational round-robin picker: first eligible index at or above rr_ptr, wrapping.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int PW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] eligible,
    input  logic [PW-1:0]   rr_ptr,
    output logic [NREQ-1:0] grant
);
    logic found_s;
    int   idx_s;

    // Walk the ring once starting at rr_ptr; the first eligible slot wins
    always_comb begin
        grant   = '0;
        found_s = 1'b0;
        idx_s   = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx_s        = (int'(rr_ptr) + k >= NREQ) ? int'(rr_ptr) + k - NREQ : int'(rr_ptr) + k;
            grant[idx_s] = eligible[idx_s] & ~found_s;
            found_s      = found_s | eligible[idx_s];
        end
    end

endmodule

// File: rtl/fadd_arbiter.sv
// Shares one pipelined fadd among NREQ requesters with round-robin issue and per-requester result buffers.
// Optional macro FADD_ARB_SUB_EN: req_sub selects a-b by inverting the sign of b at issue.
module fadd_arbiter
    import fpu_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int FADD_LAT = FADD_LATENCY
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*32-1:0]   req_a,
    input  logic [NREQ*32-1:0]   req_b,
    input  logic [NREQ-1:0]      req_sub,
    output logic [NREQ-1:0]      resp_valid,
    input  logic [NREQ-1:0]      resp_ready,
    output logic [NREQ*32-1:0]   resp_data,
    output logic                 busy
);
    localparam int PW = $clog2(NREQ);

    arb_state_t          state_r     [NREQ];
    arb_state_t          state_nxt_s [NREQ];
    fadd_tag_t           tag_r       [FADD_LAT];
    logic [NREQ-1:0]     eligible_s, grant_s, ret_s, resp_valid_r;
    logic [PW-1:0]       rr_ptr_r, grant_id_s;
    logic                grant_any_s, busy_nxt_s, busy_r, tag_last_vld_s;
    logic [31:0]         op_a_s, op_b_s, fadd_result_s;
    logic                fadd_out_valid_s;
    logic [NREQ*32-1:0]  resp_data_r;

    // Nothing is accepted while reset is asserted, so req_ready reads 0 during reset.
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            eligible_s[i] = req_valid[i] & (state_r[i] == ARB_IDLE) & rst_n;
        end
    end

    rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_rr (
        .eligible (eligible_s),
        .rr_ptr   (rr_ptr_r),
        .grant    (grant_s)
    );

    // Encode the one-hot grant and select the issued operands
    always_comb begin
        grant_id_s = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_s[i]) grant_id_s = PW'(i);
            else            grant_id_s = grant_id_s;
        end
        grant_any_s = |grant_s;
        op_a_s      = req_a[grant_id_s*32 +: 32];
`ifdef FADD_ARB_SUB_EN
        op_b_s      = {req_b[grant_id_s*32 + 31] ^ req_sub[grant_id_s], req_b[grant_id_s*32 +: 31]};
`else
        op_b_s      = req_b[grant_id_s*32 +: 32];
`endif
    end

`ifndef FADD_ARB_SUB_EN
    logic unused_sub_s;
    assign unused_sub_s = ^req_sub;
`endif

    fadd u_fadd (
        .clk         (clk),
        .rst_n       (rst_n),
        .input_valid (grant_any_s),
        .input_a     (op_a_s),
        .input_b     (op_b_s),
        .out_valid   (fadd_out_valid_s),
        .result      (fadd_result_s)
    );

    // Round-robin pointer moves past the winner only on a grant
    always_ff @(posedge clk) begin
        if (!rst_n)           rr_ptr_r <= '0;
        else if (grant_any_s) rr_ptr_r <= (grant_id_s == PW'(NREQ - 1)) ? '0 : grant_id_s + PW'(1);
    end

    // Tag pipe shadows the fadd stages so the last stage names the owner of out_valid
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < FADD_LAT; k++) tag_r[k] <= '0;
        end else begin
            tag_r[0].vld <= grant_any_s;
            tag_r[0].id  <= ARB_ID_W'(grant_id_s);
            for (int k = 1; k < FADD_LAT; k++) tag_r[k] <= tag_r[k-1];
        end
    end

    assign tag_last_vld_s = tag_r[FADD_LAT-1].vld;

    // Per-requester next state: IDLE -> INFLIGHT -> HOLD -> IDLE
    always_comb begin
        busy_nxt_s = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            ret_s[i] = fadd_out_valid_s & tag_last_vld_s & (tag_r[FADD_LAT-1].id == ARB_ID_W'(i));
            case (state_r[i])
                ARB_IDLE:     state_nxt_s[i] = grant_s[i] ? ARB_INFLIGHT : ARB_IDLE;
                ARB_INFLIGHT: state_nxt_s[i] = ret_s[i] ? ARB_HOLD : ARB_INFLIGHT;
                ARB_HOLD:     state_nxt_s[i] = (resp_valid_r[i] & resp_ready[i]) ? ARB_IDLE : ARB_HOLD;
                default:      state_nxt_s[i] = ARB_IDLE;
            endcase
            busy_nxt_s = busy_nxt_s | (state_nxt_s[i] != ARB_IDLE);
        end
    end

    // State, result buffers and registered status outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREQ; i++) state_r[i] <= ARB_IDLE;
            resp_valid_r <= '0;
            resp_data_r  <= '0;
            busy_r       <= 1'b0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                state_r[i]      <= state_nxt_s[i];
                resp_valid_r[i] <= (state_nxt_s[i] == ARB_HOLD);
                if (ret_s[i]) resp_data_r[i*32 +: 32] <= fadd_result_s;
            end
            busy_r <= busy_nxt_s;
        end
    end

    assign req_ready  = grant_s;
    assign resp_valid = resp_valid_r;
    assign resp_data  = resp_data_r;
    assign busy       = busy_r;

endmodule

// File: tb/tb_fadd_arbiter.sv
// Directed + randomized bench for fadd_arbiter against a cycle-level reference model using integer-valued floats.
module tb_fadd_arbiter;
    localparam int N   = 4;
    localparam int LAT = 3;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req_valid, req_ready, req_sub, resp_valid, resp_ready;
    logic [N*32-1:0] req_a, req_b, resp_data;
    logic            busy;

    always #5 clk = ~clk;

    fadd_arbiter #(.NREQ(N), .FADD_LAT(LAT)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_sub(req_sub), .resp_valid(resp_valid),
        .resp_ready(resp_ready), .resp_data(resp_data), .busy(busy)
    );

    fadd_arbiter_chk u_chk (
        .clk(clk), .rst_n(rst_n), .tag_vld(dut.tag_last_vld_s), .out_valid(dut.fadd_out_valid_s)
    );

    int          errors = 0;
    int          checks = 0;
    int          op_a [N];
    int          op_b [N];
    bit          owed [N];
    int          ready_at [N];
    logic [31:0] exp_data [N];
    int          ptr = 0;
    int          cyc = 0;
    int          gq [$];
    int          gcount [N];

    // Exact float encoding of a small integer
    function automatic logic [31:0] i2f(input int v);
        logic [31:0] m, sh;
        int p;
        m = (v < 0) ? 32'(-v) : 32'(v);
        if (m == 32'd0) return 32'd0;
        p = 0;
        for (int k = 0; k < 31; k++) if (m[k]) p = k;
        sh = m << (23 - p);
        return {(v < 0) ? 1'b1 : 1'b0, 8'(127 + p), sh[22:0]};
    endfunction

    function automatic int model_sum(input int a, input int b, input logic s);
`ifdef FADD_ARB_SUB_EN
        return s ? a - b : a + b;
`else
        return (s === 1'bx) ? 0 : a + b;
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) owed[i] = 1'b0;
        ptr = 0;
    endtask

    // One clock cycle: drive operands, compare against the model, advance the model
    task automatic step();
        logic [N-1:0] eg, ev;
        logic any_owed;
        int g, idx;
        for (int i = 0; i < N; i++) begin
            req_a[32*i +: 32] = i2f(op_a[i]);
            req_b[32*i +: 32] = i2f(op_b[i]);
        end
        #1;
        eg = '0; g = -1; any_owed = 1'b0;
        for (int k = 0; k < N; k++) begin
            idx = (ptr + k) % N;
            if (rst_n && g < 0 && req_valid[idx] && !owed[idx]) begin
                eg[idx] = 1'b1;
                g = idx;
            end
        end
        for (int i = 0; i < N; i++) begin
            ev[i] = owed[i] && (cyc >= ready_at[i]);
            any_owed = any_owed | owed[i];
        end
        check("req_ready", 32'(req_ready), 32'(eg));
        check("resp_valid", 32'(resp_valid), 32'(ev));
        check("busy", 32'(busy), 32'(any_owed));
        for (int i = 0; i < N; i++)
            if (ev[i]) check("resp_data", resp_data[32*i +: 32], exp_data[i]);
        for (int i = 0; i < N; i++)
            if (req_ready[i]) begin gq.push_back(i); gcount[i]++; end
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else begin
            for (int i = 0; i < N; i++) if (ev[i] && resp_ready[i]) owed[i] = 1'b0;
            if (g >= 0) begin
                owed[g]     = 1'b1;
                ready_at[g] = cyc + LAT + 1;
                exp_data[g] = i2f(model_sum(op_a[g], op_b[g], req_sub[g]));
                ptr         = (g + 1) % N;
            end
        end
        #1;
        cyc++;
    endtask

    initial begin
        logic [31:0] d0;
        int hold, n;
        bit seen;
        for (int i = 0; i < N; i++) begin op_a[i] = 0; op_b[i] = 0; gcount[i] = 0; ready_at[i] = 0; exp_data[i] = 32'd0; end
        model_reset();
        req_valid = 4'hF; resp_ready = 4'h0; req_sub = 4'h0; req_a = '0; req_b = '0;
        repeat (2) @(posedge clk);
        #2;
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        for (int i = 0; i < N; i++) check("rst_resp_data", resp_data[32*i +: 32], 32'd0);
        req_valid = 4'h0;
        rst_n = 1'b1;
        cyc = 0;

        // Test 1: 1.0 + 2.0 granted on cycle 0, result visible on cycle 4
        resp_ready = 4'hF;
        op_a[0] = 1; op_b[0] = 2; req_valid = 4'b0001;
        step();
        req_valid = 4'b0000;
        repeat (3) step();
        check("t1_cycle", 32'(cyc), 32'd4);
        check("t1_valid", 32'(resp_valid[0]), 32'd1);
        check("t1_data", resp_data[31:0], 32'h40400000);
        step();

        // Test 2: 3.0 with sub=1 against 1.0
        op_a[1] = 3; op_b[1] = 1; req_sub = 4'b0010; req_valid = 4'b0010;
        step();
        req_valid = 4'b0000;
        repeat (3) step();
        check("t2_valid", 32'(resp_valid[1]), 32'd1);
`ifdef FADD_ARB_SUB_EN
        check("t2_data", resp_data[63:32], 32'h40000000);
`else
        check("t2_data", resp_data[63:32], 32'h40800000);
`endif
        step();
        req_sub = 4'b0000;

        // Test 3: all requesters from a fresh pointer
        rst_n = 1'b0; step(); rst_n = 1'b1;
        for (int i = 0; i < N; i++) begin op_a[i] = 10 * (i + 1); op_b[i] = i - 7; end
        gq.delete();
        req_valid = 4'hF;
        repeat (16) step();
        check("t3_count", 32'(gq.size() >= 8), 32'd1);
        for (int k = 0; k < 8; k++) check("t3_order", 32'(gq[k]), 32'(k % 4));
        req_valid = 4'h0;
        repeat (8) step();

        // Test 4: req0 stalls its result buffer while req2 keeps flowing
        op_a[0] = 100; op_b[0] = -37; op_a[2] = 5; op_b[2] = 250;
        resp_ready = 4'b1110; req_valid = 4'b0101;
        gcount[2] = 0; hold = 0; seen = 1'b0; d0 = 32'd0;
        for (int t = 0; t < 16; t++) begin
            step();
            if (resp_valid[0]) begin
                if (!seen) begin d0 = resp_data[31:0]; seen = 1'b1; end
                else check("t4_stable", resp_data[31:0], d0);
                check("t4_ready0", 32'(req_ready[0]), 32'd0);
                hold++;
            end
        end
        check("t4_hold", 32'(hold >= 10), 32'd1);
        check("t4_req2", 32'(gcount[2] >= 3), 32'd1);
        resp_ready = 4'hF; req_valid = 4'h0;
        repeat (8) step();

        // Test 5: reset right after granting req3
        op_a[3] = 7; op_b[3] = 9; req_valid = 4'b1000;
        step();
        rst_n = 1'b0; req_valid = 4'b0000;
        step();
        rst_n = 1'b1;
        check("t5_resp_valid", 32'(resp_valid), 32'd0);
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_req_ready", 32'(req_ready), 32'd0);
        check("t5_data3", resp_data[127:96], 32'd0);
        seen = 1'b0;
        repeat (8) begin step(); if (resp_valid[3]) seen = 1'b1; end
        check("t5_no_resp3", 32'(seen), 32'd0);

        // Test 6: re-grant only the cycle after the handshake
        op_a[2] = -12; op_b[2] = 4; resp_ready = 4'b0100; req_valid = 4'b0100;
        n = 0;
        while (!resp_valid[2] && n < 20) begin step(); n++; end
        check("t6_found", 32'(resp_valid[2]), 32'd1);
        check("t6_ready_hs", 32'(req_ready[2]), 32'd0);
        step();
        check("t6_ready_next", 32'(req_ready[2]), 32'd1);
        req_valid = 4'h0; resp_ready = 4'hF;
        repeat (8) step();

        // Randomized traffic with occasional reset
        for (int t = 0; t < 400; t++) begin
            req_valid  = 4'($urandom);
            resp_ready = 4'($urandom) | 4'($urandom);
            req_sub    = 4'($urandom);
            for (int i = 0; i < N; i++) begin
                op_a[i] = int'($urandom_range(2000, 0)) - 1000;
                op_b[i] = int'($urandom_range(2000, 0)) - 1000;
            end
            rst_n = ($urandom_range(99, 0) != 0);
            step();
        end
        rst_n = 1'b1; req_valid = 4'h0; resp_ready = 4'hF;
        repeat (8) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
